ram_fifo_ctrl: RTL



---
 rtl/ram_fifo_pkg.sv | 15 +
 rtl/ram_fifo_outbuf.sv | 60 ++++++
 rtl/ram_fifo_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg: shared defaults and types for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

    // Read/write pointers carry one extra wrap bit above the RAM address.
    typedef logic [ADDR_W_DEF:0] ptr_t;
    // Total occupancy reaches DEPTH+2, which still fits in ADDR_W+1 bits.
    typedef logic [ADDR_W_DEF:0] cnt_t;
    // Output buffer fill level, 0..2.
    typedef logic [1:0]          buf_cnt_t;

endpackage

// File: rtl/ram_fifo_outbuf.sv
// ram_fifo_outbuf: 2-entry output buffer that absorbs the RAM read latency.
// Words land from the RAM read port at the tail and leave from the head.
module ram_fifo_outbuf
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              land,
    input  logic [DATA_W-1:0] land_data,
    input  logic              pop,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        buf_cnt
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;

    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = head_q;

    // Buffer update: land at tail, pop from head, both together keep the level.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            buf_cnt <= '0;
        end else begin
            case ({land, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) begin
                        head_q <= land_data;
                    end else begin
                        tail_q <= land_data;
                    end
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    // With one entry the landing word becomes the new head;
                    // with two the tail moves up and the landing word refills it.
                    if (buf_cnt == 2'd1) begin
                        head_q <= land_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= land_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller driving an external 1024x16 simple dual-port
// RAM with 1-cycle registered reads. A 2-entry output buffer keeps the output
// stream at full throughput.
// Optional: define RAM_FIFO_WATERMARK_EN to add almost_full/almost_empty.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
`ifdef RAM_FIFO_WATERMARK_EN
    ,
    parameter int unsigned AF_LVL = 1000,
    parameter int unsigned AE_LVL = 8
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              read_enable,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [DATA_W-1:0] read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
`ifdef RAM_FIFO_WATERMARK_EN
    output logic              almost_full,
    output logic              almost_empty,
`endif
    output logic [ADDR_W:0]   count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic [ADDR_W:0] ram_cnt;
    logic            inflight;
    logic [1:0]      buf_cnt;
    logic [2:0]      occ;
    logic            push;
    logic            pop;

    assign ram_cnt      = wr_ptr - rd_ptr;
    assign in_ready     = (ram_cnt != (ADDR_W+1)'(DEPTH));
    assign push         = in_valid && in_ready;
    assign pop          = out_valid && out_ready;

    assign write_enable = push;
    assign write_addr   = wr_ptr[ADDR_W-1:0];
    assign write_data   = in_data;

    // Words already committed to the buffer side: stored plus in flight.
    assign occ          = {1'b0, buf_cnt} + {2'b00, inflight};
    assign read_enable  = (ram_cnt != '0) && (occ < (3'd2 + {2'b00, pop}));
    assign read_addr    = rd_ptr[ADDR_W-1:0];

    assign count        = ram_cnt
                        + {{(ADDR_W-1){1'b0}}, buf_cnt}
                        + {{ADDR_W{1'b0}}, inflight};

    // Pointer advance on push/read issue; inflight tracks the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr + {{ADDR_W{1'b0}}, push};
            rd_ptr   <= rd_ptr + {{ADDR_W{1'b0}}, read_enable};
            inflight <= read_enable;
        end
    end

    ram_fifo_outbuf #(
        .DATA_W (DATA_W)
    ) u_outbuf (
        .clk       (clk),
        .rst       (rst),
        .land      (inflight),
        .land_data (read_data),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (out_data),
        .buf_cnt   (buf_cnt)
    );

`ifdef RAM_FIFO_WATERMARK_EN
    // Total occupancy only moves on external push/pop; RAM-to-buffer
    // transfers are internal and leave it unchanged.
    logic [ADDR_W+1:0] count_next;

    assign count_next = {1'b0, count}
                      + {{(ADDR_W+1){1'b0}}, push}
                      - {{(ADDR_W+1){1'b0}}, pop};

    // Watermark flags registered from next-state occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_next >= (ADDR_W+2)'(AF_LVL));
            almost_empty <= (count_next <= (ADDR_W+2)'(AE_LVL));
        end
    end
`endif

endmodule
